// File: rtl/xip_pkg.sv
// Shared XIP definitions: flash op encodings, arbiter FSM states and master index type.
package xip_pkg;

    localparam logic [1:0] XIP_OP_READ  = 2'd0;
    localparam logic [1:0] XIP_OP_PROG  = 2'd1;
    localparam logic [1:0] XIP_OP_ERASE = 2'd2;

    // Bit 23 of a write address selects sector erase instead of program.
    localparam int unsigned XIP_ERASE_BIT = 23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_HIT  = 2'd3
    } arb_state_e;

    typedef logic mst_idx_t;

    localparam mst_idx_t MST_IFETCH = 1'b0;
    localparam mst_idx_t MST_DATA   = 1'b1;

    function automatic logic [1:0] xip_op(input logic we, input logic [31:0] addr);
        if (!we) return XIP_OP_READ;
        return addr[XIP_ERASE_BIT] ? XIP_OP_ERASE : XIP_OP_PROG;
    endfunction

endpackage

// File: rtl/xip_arb.sv
// Two-master OBI arbiter in front of the XIP flash core, with a one-word read buffer.
module xip_arb
    import xip_pkg::*;
#(
    parameter bit BUF_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,

    output logic        s_req_o,
    output logic        s_we_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    input  logic        s_gnt_i,
    input  logic        s_rvalid_i,
    input  logic [31:0] s_rdata_i
);

    arb_state_e  state_q, state_d;
    mst_idx_t    owner_q, owner_d;
    mst_idx_t    last_q, last_d;
    mst_idx_t    winner;

    logic        buf_vld_q, buf_vld_d;
    logic [29:0] buf_tag_q, buf_tag_d;
    logic [31:0] buf_data_q, buf_data_d;

    // Address/direction of the flash access in flight, captured at grant since
    // the master may change its bus once granted.
    logic [29:0] rsp_tag_q, rsp_tag_d;
    logic        rsp_we_q, rsp_we_d;

    logic        win_we;
    logic [31:0] win_addr;
    logic        hit;

    logic        own_we;
    logic [3:0]  own_be;
    logic [31:0] own_addr;
    logic [31:0] own_data;

    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [31:0] rdata;

    always_comb begin
        if (m0_req_i && m1_req_i) begin
            winner = (last_q == MST_IFETCH) ? MST_DATA : MST_IFETCH;
        end else if (m1_req_i) begin
            winner = MST_DATA;
        end else begin
            winner = MST_IFETCH;
        end
    end

    assign win_we   = (winner == MST_DATA) ? m1_we_i   : m0_we_i;
    assign win_addr = (winner == MST_DATA) ? m1_addr_i : m0_addr_i;
    assign hit      = BUF_EN && buf_vld_q && !win_we && (win_addr[31:2] == buf_tag_q);

    assign own_we   = (owner_q == MST_DATA) ? m1_we_i   : m0_we_i;
    assign own_be   = (owner_q == MST_DATA) ? m1_be_i   : m0_be_i;
    assign own_addr = (owner_q == MST_DATA) ? m1_addr_i : m0_addr_i;
    assign own_data = (owner_q == MST_DATA) ? m1_data_i : m0_data_i;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        buf_vld_d  = buf_vld_q;
        buf_tag_d  = buf_tag_q;
        buf_data_d = buf_data_q;
        rsp_tag_d  = rsp_tag_q;
        rsp_we_d   = rsp_we_q;
        s_req_o    = 1'b0;
        s_we_o     = 1'b0;
        s_be_o     = 4'h0;
        s_addr_o   = 32'h0;
        s_wdata_o  = 32'h0;
        gnt        = 2'b00;
        rvalid     = 2'b00;
        rdata      = 32'h0;

        case (state_q)
            ST_IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    owner_d = winner;
                    if (hit) begin
                        gnt[winner] = 1'b1;
                        last_d      = winner;
                        state_d     = ST_HIT;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                s_req_o      = 1'b1;
                s_we_o       = own_we;
                s_be_o       = own_be;
                s_addr_o     = own_addr;
                s_wdata_o    = own_data;
                gnt[owner_q] = s_gnt_i;
                if (s_gnt_i) begin
                    last_d    = owner_q;
                    rsp_we_d  = own_we;
                    rsp_tag_d = own_addr[31:2];
                    // Program and erase both make the buffered word untrustworthy.
                    if (own_we) begin
                        buf_vld_d = 1'b0;
                    end
                    state_d = ST_RSP;
                end
            end

            ST_RSP: begin
                if (s_rvalid_i) begin
                    rvalid[owner_q] = 1'b1;
                    rdata           = s_rdata_i;
                    if (!rsp_we_q) begin
                        buf_vld_d  = BUF_EN;
                        buf_tag_d  = rsp_tag_q;
                        buf_data_d = s_rdata_i;
                    end
                    state_d = ST_IDLE;
                end
            end

            ST_HIT: begin
                rvalid[owner_q] = 1'b1;
                rdata           = buf_data_q;
                state_d         = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            owner_q    <= MST_IFETCH;
            last_q     <= MST_DATA;
            buf_vld_q  <= 1'b0;
            buf_tag_q  <= 30'h0;
            buf_data_q <= 32'h0;
            rsp_tag_q  <= 30'h0;
            rsp_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            buf_vld_q  <= buf_vld_d;
            buf_tag_q  <= buf_tag_d;
            buf_data_q <= buf_data_d;
            rsp_tag_q  <= rsp_tag_d;
            rsp_we_q   <= rsp_we_d;
        end
    end

    assign m0_gnt_o    = gnt[0];
    assign m1_gnt_o    = gnt[1];
    assign m0_rvalid_o = rvalid[0];
    assign m1_rvalid_o = rvalid[1];
    assign m0_rdata_o  = rvalid[0] ? rdata : 32'h0;
    assign m1_rdata_o  = rvalid[1] ? rdata : 32'h0;

endmodule

// File: tb/tb_xip_arb.sv
// Bench for xip_arb: behavioural flash model, randomized traffic and directed arbitration/buffer scenarios.
module tb_xip_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    logic [1:0]  m_req, m_we;
    logic [3:0]  m_be   [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_data [2];
    logic        m0_gnt, m1_gnt, m0_rv, m1_rv;
    logic [31:0] m0_rd, m1_rd;

    logic        s_req, s_we, s_gnt, s_rv;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata, s_rdata;

    logic        nb_req, nb_gnt, nb_rv, nb_m1_gnt, nb_m1_rv;
    logic [31:0] nb_addr, nb_rd, nb_m1_rd;
    logic        nb_sreq, nb_swe, nb_srv;
    logic [3:0]  nb_sbe;
    logic [31:0] nb_saddr, nb_swdata, nb_srdata;
    wire         nb_sgnt = nb_sreq;

    xip_arb #(.BUF_EN(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_req_i(m_req[0]), .m0_we_i(m_we[0]), .m0_be_i(m_be[0]), .m0_addr_i(m_addr[0]),
        .m0_data_i(m_data[0]), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rv), .m0_rdata_o(m0_rd),
        .m1_req_i(m_req[1]), .m1_we_i(m_we[1]), .m1_be_i(m_be[1]), .m1_addr_i(m_addr[1]),
        .m1_data_i(m_data[1]), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rv), .m1_rdata_o(m1_rd),
        .s_req_o(s_req), .s_we_o(s_we), .s_be_o(s_be), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
        .s_gnt_i(s_gnt), .s_rvalid_i(s_rv), .s_rdata_i(s_rdata)
    );

    xip_arb #(.BUF_EN(1'b0)) dut_nb (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_req_i(nb_req), .m0_we_i(1'b0), .m0_be_i(4'hF), .m0_addr_i(nb_addr),
        .m0_data_i(32'h0), .m0_gnt_o(nb_gnt), .m0_rvalid_o(nb_rv), .m0_rdata_o(nb_rd),
        .m1_req_i(1'b0), .m1_we_i(1'b0), .m1_be_i(4'h0), .m1_addr_i(32'h0),
        .m1_data_i(32'h0), .m1_gnt_o(nb_m1_gnt), .m1_rvalid_o(nb_m1_rv), .m1_rdata_o(nb_m1_rd),
        .s_req_o(nb_sreq), .s_we_o(nb_swe), .s_be_o(nb_sbe), .s_addr_o(nb_saddr), .s_wdata_o(nb_swdata),
        .s_gnt_i(nb_sgnt), .s_rvalid_i(nb_srv), .s_rdata_i(nb_srdata)
    );

    // Flash contents: untouched words read back an address-derived pattern.
    logic [31:0] mem [logic [29:0]];
    function automatic logic [31:0] mem_rd(input logic [29:0] a);
        return mem.exists(a) ? mem[a] : ({a, 2'b00} ^ 32'h5A5A_1234);
    endfunction

    int gnt_lat = -1, rv_lat = -1;
    int sgnt_cyc = -1, srv_cyc = -1;
    int f_ph = 0, f_cnt = 0;
    logic        f_we;
    logic [3:0]  f_be;
    logic [31:0] f_addr, f_wdata;

    initial begin
        s_gnt = 0; s_rv = 0; s_rdata = 0;
        forever begin
            @(posedge clk); #1;
            s_gnt = 0; s_rv = 0; s_rdata = 0;
            if (!rst_n) begin
                f_ph = 0;
            end else begin
                if (f_ph == 0 && s_req) begin
                    f_cnt = (gnt_lat < 0) ? int'($urandom_range(0, 2)) : gnt_lat;
                    f_ph = 1;
                end
                if (f_ph == 1) begin
                    if (f_cnt == 0) begin
                        s_gnt = 1; sgnt_cyc = cyc;
                        f_we = s_we; f_be = s_be; f_addr = s_addr; f_wdata = s_wdata;
                        f_cnt = (rv_lat < 0) ? int'($urandom_range(0, 2)) : rv_lat;
                        f_ph = 2;
                    end else f_cnt--;
                end else if (f_ph == 2) begin
                    if (f_cnt == 0) begin
                        if (f_we) begin
                            if (f_addr[23]) mem[f_addr[31:2]] = 32'hFFFF_FFFF;
                            else begin
                                logic [31:0] w;
                                w = mem_rd(f_addr[31:2]);
                                for (int b = 0; b < 4; b++)
                                    if (f_be[b]) w[8*b +: 8] = f_wdata[8*b +: 8];
                                mem[f_addr[31:2]] = w;
                            end
                            s_rdata = $urandom;
                        end else begin
                            s_rdata = mem_rd(f_addr[31:2]);
                        end
                        s_rv = 1; srv_cyc = cyc; f_ph = 0;
                    end else f_cnt--;
                end
            end
        end
    end

    // Fixed one-cycle responder for the unbuffered instance.
    logic        nb_seen;
    logic [31:0] nb_seen_addr;
    initial begin
        nb_srv = 0; nb_srdata = 0;
        forever begin
            @(negedge clk); nb_seen = nb_sreq; nb_seen_addr = nb_saddr;
            @(posedge clk); #1;
            nb_srv = nb_seen && rst_n;
            nb_srdata = nb_srv ? (nb_seen_addr ^ 32'h0F0F_0F0F) : 32'h0;
        end
    end

    int sreq_n = 0, nb_sreq_n = 0, rv0_n = 0, rv1_n = 0, bad_rd = 0;
    always @(negedge clk) begin
        if (s_req) sreq_n <= sreq_n + 1;
        if (nb_sreq) nb_sreq_n <= nb_sreq_n + 1;
        if (m0_rv) rv0_n <= rv0_n + 1;
        if (m1_rv) rv1_n <= rv1_n + 1;
        if ((!m0_rv && m0_rd != 0) || (!m1_rv && m1_rd != 0) || (m0_rv && m1_rv))
            bad_rd <= bad_rd + 1;
    end

    function automatic logic gnt_of(input int m); return m ? m1_gnt : m0_gnt; endfunction
    function automatic logic rv_of(input int m);  return m ? m1_rv  : m0_rv;  endfunction
    function automatic logic [31:0] rd_of(input int m); return m ? m1_rd : m0_rd; endfunction

    task automatic xact(input int m, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output int gc, output int rc, output logic [31:0] rd);
        m_req[m] = 1; m_we[m] = we; m_addr[m] = addr; m_data[m] = wd; m_be[m] = 4'hF;
        gc = -1; rc = -1; rd = 32'h0;
        for (int i = 0; i < 40 && gc < 0; i++) begin
            @(negedge clk); if (gnt_of(m)) gc = cyc;
            @(posedge clk); #1;
        end
        m_req[m] = 0; m_we[m] = 0; m_addr[m] = 0; m_data[m] = 0;
        if (gc >= 0)
            for (int i = 0; i < 40 && rc < 0; i++) begin
                @(negedge clk); if (rv_of(m)) begin rc = cyc; rd = rd_of(m); end
                @(posedge clk); #1;
            end
    endtask

    task automatic apply_reset;
        rst_n = 0; m_req = 0; nb_req = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
    endtask

    function automatic logic [171:0] all_outs;
        return {m0_gnt, m1_gnt, m0_rv, m1_rv, m0_rd, m1_rd, s_req, s_we, s_be, s_addr, s_wdata,
                nb_gnt, nb_rv, nb_sreq};
    endfunction

    task automatic test_reset;
        rst_n = 0; m_req = 0; nb_req = 0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        total++; if (all_outs() !== '0) begin bad++; $display("FAIL reset_outs_during got=%h want=0", all_outs()); end
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        total++; if (all_outs() !== '0) begin bad++; $display("FAIL reset_outs_after got=%h want=0", all_outs()); end
        @(posedge clk); #1;
    endtask

    task automatic test_buffer_hit;
        int gc, rc, s0; logic [31:0] rd, first;
        s0 = sreq_n;
        xact(0, 0, 32'h0000_0100, 0, gc, rc, first);
        total++; if (rc < 0) begin bad++; $display("FAIL hit_first_timeout got=%0d want>=0", rc); end
        total++; if (first !== mem_rd(30'h40)) begin bad++; $display("FAIL hit_first_data got=%h want=%h", first, mem_rd(30'h40)); end
        total++; if (gc !== sgnt_cyc || rc !== srv_cyc) begin bad++;
            $display("FAIL miss_latency got=%0d/%0d want=%0d/%0d", gc, rc, sgnt_cyc, srv_cyc); end
        total++; if (sreq_n - s0 < 1) begin bad++; $display("FAIL hit_first_sreq got=%0d want>=1", sreq_n - s0); end
        s0 = sreq_n;
        xact(0, 0, 32'h0000_0100, 0, gc, rc, rd);
        total++; if (sreq_n - s0 !== 0) begin bad++; $display("FAIL hit_second_sreq got=%0d want=0", sreq_n - s0); end
        total++; if (rc - gc !== 1 || gc < 0) begin bad++; $display("FAIL hit_latency got=%0d want=1", rc - gc); end
        total++; if (rd !== first) begin bad++; $display("FAIL hit_second_data got=%h want=%h", rd, first); end
    endtask

    task automatic test_round_robin;
        int g0, r0, g1, r1; logic [31:0] d0, d1;
        apply_reset();
        gnt_lat = 0;
        fork
            xact(0, 0, 32'h0000_0800, 0, g0, r0, d0);
            xact(1, 0, 32'h0000_0800, 0, g1, r1, d1);
        join
        total++; if (!(g0 >= 0 && g0 < g1)) begin bad++; $display("FAIL rr_first_m0 got g0=%0d g1=%0d want g0<g1", g0, g1); end
        total++; if (g1 !== r0 + 1) begin bad++; $display("FAIL rr_m1_after_rv got=%0d want=%0d", g1, r0 + 1); end
        total++; if (d0 !== mem_rd(30'h200) || d1 !== d0) begin bad++;
            $display("FAIL rr_data got=%h/%h want=%h", d0, d1, mem_rd(30'h200)); end
        fork
            xact(0, 0, 32'h0000_0800, 0, g0, r0, d0);
            xact(1, 0, 32'h0000_0800, 0, g1, r1, d1);
        join
        total++; if (!(g0 >= 0 && g0 < g1 && g1 == r0 + 1)) begin bad++;
            $display("FAIL rr_second_tie got g0=%0d g1=%0d r0=%0d want m0 first", g0, g1, r0); end
        gnt_lat = -1;
    endtask

    task automatic test_write_invalidate;
        int gc, rc, s0; logic [31:0] rd;
        xact(0, 0, 32'h0000_0040, 0, gc, rc, rd);
        xact(1, 1, 32'h0000_0040, 32'hA5A5_A5A5, gc, rc, rd);
        total++; if (rc < 0) begin bad++; $display("FAIL wr_rvalid_timeout got=%0d want>=0", rc); end
        s0 = sreq_n;
        xact(0, 0, 32'h0000_0040, 0, gc, rc, rd);
        total++; if (sreq_n - s0 < 1) begin bad++; $display("FAIL wr_inval_miss got=%0d want>=1", sreq_n - s0); end
        total++; if (rd !== 32'hA5A5_A5A5) begin bad++; $display("FAIL wr_new_data got=%h want=a5a5a5a5", rd); end
    endtask

    task automatic test_erase;
        int gc, rc, s0, a0, a1; logic [31:0] rd;
        xact(0, 0, 32'h0080_1000, 0, gc, rc, rd);
        a0 = rv0_n; a1 = rv1_n;
        xact(1, 1, 32'h0080_1000, 32'h0, gc, rc, rd);
        total++; if (rv0_n - a0 !== 0 || rv1_n - a1 !== 1) begin bad++;
            $display("FAIL erase_routing got m0=%0d m1=%0d want 0/1", rv0_n - a0, rv1_n - a1); end
        s0 = sreq_n;
        xact(0, 0, 32'h0080_1000, 0, gc, rc, rd);
        total++; if (sreq_n - s0 < 1 || rd !== 32'hFFFF_FFFF) begin bad++;
            $display("FAIL erase_inval got sreq=%0d data=%h want miss/ffffffff", sreq_n - s0, rd); end
    endtask

    task automatic test_reset_mid;
        int gc, rc, s0, a0; logic [31:0] rd; logic g;
        xact(0, 0, 32'h0000_0040, 0, gc, rc, rd);
        rv_lat = 6; a0 = rv0_n; g = 0;
        m_req[0] = 1; m_addr[0] = 32'h0000_0300;
        for (int i = 0; i < 40 && !g; i++) begin
            @(negedge clk); if (m0_gnt) g = 1;
            @(posedge clk); #1;
        end
        m_req[0] = 0; m_addr[0] = 0;
        total++; if (g !== 1'b1) begin bad++; $display("FAIL rstmid_gnt_timeout got=%b want=1", g); end
        rst_n = 0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1; rv_lat = -1;
        repeat (10) begin @(posedge clk); #1; end
        total++; if (rv0_n - a0 !== 0) begin bad++; $display("FAIL rstmid_no_rvalid got=%0d want=0", rv0_n - a0); end
        total++; if (all_outs() !== '0) begin bad++; $display("FAIL rstmid_idle_outs got=%h want=0", all_outs()); end
        s0 = sreq_n;
        xact(0, 0, 32'h0000_0040, 0, gc, rc, rd);
        total++; if (sreq_n - s0 < 1 || rd !== mem_rd(30'h10)) begin bad++;
            $display("FAIL rstmid_miss got sreq=%0d data=%h want miss/%h", sreq_n - s0, rd, mem_rd(30'h10)); end
    endtask

    task automatic test_random;
        logic [31:0] pool [6];
        logic mvld; logic [29:0] mtag;
        int gc, rc, s0, m; logic we, exp_hit; logic [31:0] a, wd, rd, exp;
        pool = '{32'h0000_0040, 32'h0000_0044, 32'h0000_0100, 32'h0080_1000, 32'h0000_0204, 32'h00FF_FFFC};
        apply_reset();
        mvld = 0; mtag = 0;
        for (int k = 0; k < 40; k++) begin
            m = int'($urandom_range(0, 1));
            we = ($urandom_range(0, 3) == 0);
            a = pool[$urandom_range(0, 5)];
            wd = $urandom;
            exp_hit = mvld && !we && (mtag == a[31:2]);
            exp = mem_rd(a[31:2]);
            s0 = sreq_n;
            xact(m, we, a, wd, gc, rc, rd);
            total++; if (rc < 0) begin bad++; $display("FAIL rnd_timeout k=%0d got=%0d want>=0", k, rc); end
            total++; if ((sreq_n == s0) !== exp_hit) begin bad++;
                $display("FAIL rnd_hit k=%0d addr=%h got=%b want=%b", k, a, sreq_n == s0, exp_hit); end
            if (!we) begin
                total++; if (rd !== exp) begin bad++; $display("FAIL rnd_data k=%0d addr=%h got=%h want=%h", k, a, rd, exp); end
                mvld = 1; mtag = a[31:2];
            end else begin
                mvld = 0;
            end
        end
    endtask

    task automatic test_nobuf;
        int s0; logic g, r; logic [31:0] rd;
        for (int k = 0; k < 3; k++) begin
            s0 = nb_sreq_n; g = 0; r = 0; rd = 0;
            nb_req = 1; nb_addr = 32'h0000_0200;
            for (int i = 0; i < 20 && !g; i++) begin
                @(negedge clk); if (nb_gnt) g = 1;
                @(posedge clk); #1;
            end
            nb_req = 0; nb_addr = 0;
            for (int i = 0; i < 20 && !r; i++) begin
                @(negedge clk); if (nb_rv) begin r = 1; rd = nb_rd; end
                @(posedge clk); #1;
            end
            total++; if (nb_sreq_n - s0 !== 1) begin bad++; $display("FAIL nobuf_sreq k=%0d got=%0d want=1", k, nb_sreq_n - s0); end
            total++; if (!r || rd !== 32'h0F0F_0D0F) begin bad++; $display("FAIL nobuf_data k=%0d got=%h want=0f0f0d0f", k, rd); end
        end
    endtask

    initial begin
        m_req = 0; m_we = 0; nb_req = 0; nb_addr = 0;
        for (int i = 0; i < 2; i++) begin m_be[i] = 0; m_addr[i] = 0; m_data[i] = 0; end
        test_reset();
        test_buffer_hit();
        test_round_robin();
        test_write_invalidate();
        test_erase();
        test_reset_mid();
        test_random();
        test_nobuf();
        @(posedge clk); #1;
        total++; if (bad_rd !== 0) begin bad++; $display("FAIL rdata_idle_zero got=%0d want=0", bad_rd); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xip_arb.md
XIP_ARB -- requirements
Module: xip_arb

Interface
REQ-001 SHALL have parameter: BUF_EN, 1, enable the 1-word read buffer (0: every read goes to flash).
REQ-002 SHALL have ports: clk_i  in  1  clock; rst_ni  in  1  reset, synchronous, active-low.
REQ-003 SHALL have per-master OBI slave ports mN_req_i in 1, mN_we_i in 1, mN_be_i in 4, mN_addr_i in 32, mN_data_i in 32, mN_gnt_o out 1, mN_rvalid_o out 1, mN_rdata_o out 32, N=0 (instruction fetch), N=1 (data).
REQ-004 SHALL have OBI master port to XIP core: s_req_o out 1, s_we_o out 1, s_be_o out 4, s_addr_o out 32, s_wdata_o out 32, s_gnt_i in 1, s_rvalid_i in 1, s_rdata_i in 32.

Function
REQ-005 SHALL share the single XIP flash port between m0 and m1, with at most one transaction outstanding.
REQ-006 SHALL use FSM states IDLE, REQ, RSP, HIT; the reset state is IDLE.
REQ-007 IDLE: the winner is the sole requester; if both request, the master not granted last wins (round robin); a last-grant pointer records the winner.
REQ-008 IDLE: the winner's read (we=0) SHALL be a buffer hit when BUF_EN=1, the buffer is valid, and addr[31:2] equals the buffer tag.
REQ-009 IDLE, hit: mN_gnt_o=1 in the same cycle, no s_req_o, next state HIT.
REQ-010 IDLE, miss: next state REQ with the owner latched; s_* is not driven in IDLE.
REQ-011 REQ: s_req_o=1 and the owner's we/be/addr/data are passed combinationally to s_*; owner mN_gnt_o = s_gnt_i; on s_gnt_i go to RSP.
REQ-012 REQ: the owner's request SHALL be held until granted (OBI rule); the other master's gnt stays 0.
REQ-013 RSP: on s_rvalid_i, the owner's mN_rvalid_o=1 and mN_rdata_o=s_rdata_i in the same cycle; next state IDLE.
REQ-014 RSP: no grants to either master; new requests wait.
REQ-015 HIT: the owner's mN_rvalid_o=1 and mN_rdata_o=buffer data, exactly 1 cycle after gnt; next state IDLE.
REQ-016 A read completing in RSP SHALL load the buffer: tag=addr[31:2], data=s_rdata_i, valid=1.
REQ-017 Any write granted (we=1, including program or sector erase at addr[23]=1) SHALL clear buffer valid in the grant cycle; a write never hits.
REQ-018 Write response: rvalid forwarded from s_rvalid_i; rdata is forwarded but is don't-care.
REQ-019 Non-owner mN_rvalid_o SHALL be 0 at all times; mN_rdata_o is 0 when rvalid is 0.
REQ-020 The round-robin pointer SHALL update on every master grant, including hits.
REQ-021 Requests are accepted back to back: IDLE can grant in the cycle after rvalid.
REQ-022 Latency: hit 1 cycle gnt->rvalid; miss = XIP core latency + 0 added cycles on gnt and rvalid.

Reset
REQ-023 On rst_ni=0 at a clk_i edge: state=IDLE, buffer valid=0, tag/data=0, pointer=m1 (so m0 wins the first tie).
REQ-024 All outputs SHALL be 0 during and after reset until a request arrives.
REQ-025 Reset mid-transaction SHALL abandon the transaction with no rvalid issued; the XIP core is reset by the same rst_ni.

Structure
REQ-026 The FSM state enum and the master index type (1 bit) SHALL live in a shared package xip_pkg, alongside the existing XIP op encodings.
REQ-027 The arbiter SHALL be flat, with no sub-module; the read buffer is inline registers.
REQ-028 The arbiter SHALL be instantiated between the core bus ports and xip_core, with no change to xip_core.

Verification
REQ-029 m0 read 0x0000_0100, then read 0x0000_0100 again -> first goes to flash; second: s_req_o stays 0, rvalid 1 cycle after gnt, same data.
REQ-030 m0 and m1 both request reads in IDLE from reset -> m0 granted first, m1 granted in the IDLE following m0's rvalid; next tie -> m0 again only after m1.
REQ-031 Read 0x40 (buffered), m1 write 0x40 data 0xA5A5_A5A5, m0 read 0x40 -> third access misses and returns the new flash data.
REQ-032 m1 erase at addr 0x0080_1000 (addr[23]=1) -> buffer invalidated, rvalid routed only to m1, m0 rvalid stays 0.
REQ-033 Assert rst_ni=0 while in RSP with s_rvalid_i pending -> no mN_rvalid_o, state IDLE, the next read of the previously buffered address misses.
REQ-034 BUF_EN=0: repeated reads of 0x0000_0200 -> every read produces s_req_o.
